// File: rtl/branch_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state encoding,
// default reset PC / bubble instruction, and the instruction width.
package branch_fetch_unit_pkg;

   localparam int unsigned INSTR_W = 32;

   localparam logic [31:0]        DEF_RESET_PC  = 32'h0000_3000;
   localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/branch_stat_counter.sv
// Wrapping event counter with enable.
// Ports: clk, rst (async, active-high), en (count this cycle), count (value).
module branch_stat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/branch_fetch_unit.sv
// Fetch stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID
// register, redirects fetch on ID-resolved branches/jumps (no delay slot)
// and squashes the single wrong-path instruction with a bubble.
// Ports:
//   clk, rst              clock, async active-high reset
//   stall                 hazard stall, freezes PC, IF/ID, counters, FSM
//   br_valid/br_result    conditional branch in ID and its comparator result
//   br_target             branch target
//   jump/jump_target      unconditional jump in ID and its target
//   imem_addr/imem_rdata  combinational instruction-memory port
//   ifid_instr/pc4/valid  IF/ID pipeline register
//   pc_misalign           sticky flag: a redirect target had [1:0] != 0
//   br_total_cnt          resolved conditional branches
//   br_taken_cnt          taken conditional branches
module branch_fetch_unit
   import branch_fetch_unit_pkg::*;
#(
   parameter logic [31:0]        RESET_PC  = DEF_RESET_PC,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               br_valid,
   input  logic               br_result,
   input  logic [31:0]        br_target,
   input  logic               jump,
   input  logic [31:0]        jump_target,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [31:0]        ifid_pc4,
   output logic               ifid_valid,
   output logic               pc_misalign,
   output logic [31:0]        br_total_cnt,
   output logic [31:0]        br_taken_cnt
);

   logic [31:0]  pc;
   logic [31:0]  pc_plus4;
   logic [31:0]  redirect_target;
   logic         br_taken;
   logic         redirect;
   fetch_state_t state;

   assign br_taken        = br_valid && br_result;
   assign redirect        = !stall && (jump || br_taken);
   // A taken branch has priority over a simultaneous jump.
   assign redirect_target = br_taken ? br_target : jump_target;
   assign pc_plus4        = pc + 32'd4;
   assign imem_addr       = pc;

   // PC register / next-PC mux
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (!stall) begin
         pc <= redirect ? {redirect_target[31:2], 2'b00} : pc_plus4;
      end
   end

   // IF/ID register; the instruction fetched alongside a redirect is the
   // wrong-path one, so it is replaced by a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_instr <= NOP_INSTR;
         ifid_pc4   <= '0;
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_pc4 <= pc_plus4;
         if (redirect) begin
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
         end else begin
            ifid_instr <= imem_rdata;
            ifid_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_misalign <= 1'b0;
      end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
         pc_misalign <= 1'b1;
      end
   end

   // Fetch-state tracking; FLUSH marks the cycle(s) where IF/ID holds a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else if (!stall) begin
         case (state)
            BOOT:    state <= RUN;
            RUN:     state <= redirect ? FLUSH : RUN;
            FLUSH:   state <= redirect ? FLUSH : RUN;
            default: state <= RUN;
         endcase
      end
   end

   branch_stat_counter #(.WIDTH(32)) u_total_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall && br_valid),
      .count (br_total_cnt)
   );

   branch_stat_counter #(.WIDTH(32)) u_taken_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (!stall && br_taken),
      .count (br_taken_cnt)
   );

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Directed bench for branch_fetch_unit with a combinational instruction
// memory whose contents are a fixed function of the address.
module tb_branch_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_valid;
   logic        br_result;
   logic [31:0] br_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic        pc_misalign;
   logic [31:0] br_total_cnt;
   logic [31:0] br_taken_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign imem_rdata = mem(imem_addr);

   branch_fetch_unit #(
      .RESET_PC  (32'h0000_3000),
      .NOP_INSTR (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .br_valid     (br_valid),
      .br_result    (br_result),
      .br_target    (br_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .ifid_instr   (ifid_instr),
      .ifid_pc4     (ifid_pc4),
      .ifid_valid   (ifid_valid),
      .pc_misalign  (pc_misalign),
      .br_total_cnt (br_total_cnt),
      .br_taken_cnt (br_taken_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      stall = 0; br_valid = 0; br_result = 0; jump = 0;
      br_target = '0; jump_target = '0;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
      check_eq({tag, ".instr"}, ifid_instr, instr);
      check_eq({tag, ".pc4"},   ifid_pc4,   pc4);
      check_eq({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
   endtask

   initial begin
      rst = 1;
      clear_ctrl();
      repeat (2) @(posedge clk);
      #1;
      // reset state
      check_eq("rst.addr", imem_addr, 32'h3000);
      check_ifid("rst", NOP, 32'h0, 1'b0);
      check_eq("rst.misalign", {31'd0, pc_misalign}, 32'd0);
      check_eq("rst.total", br_total_cnt, 32'd0);
      check_eq("rst.taken", br_taken_cnt, 32'd0);
      rst = 0;

      // 1: sequential fetch
      for (int i = 1; i <= 3; i++) begin
         step();
         check_eq("seq.addr", imem_addr, 32'h3000 + 32'(4 * i));
         check_ifid("seq", mem(32'h3000 + 32'(4 * (i - 1))), 32'h3000 + 32'(4 * i), 1'b1);
      end

      // 2: taken branch at PC 0x300C
      br_valid = 1; br_result = 1; br_target = 32'h3100;
      step();
      clear_ctrl();
      check_eq("taken.addr", imem_addr, 32'h3100);
      check_ifid("taken", NOP, 32'h3010, 1'b0);
      check_eq("taken.total", br_total_cnt, 32'd1);
      check_eq("taken.taken", br_taken_cnt, 32'd1);
      step();
      check_eq("after.addr", imem_addr, 32'h3104);
      check_ifid("after", mem(32'h3100), 32'h3104, 1'b1);

      // 3: not-taken branch
      br_valid = 1; br_result = 0; br_target = 32'h3300;
      step();
      clear_ctrl();
      check_eq("nt.addr", imem_addr, 32'h3108);
      check_ifid("nt", mem(32'h3104), 32'h3108, 1'b1);
      check_eq("nt.total", br_total_cnt, 32'd2);
      check_eq("nt.taken", br_taken_cnt, 32'd1);

      // 4: stall with a taken branch for 3 cycles
      stall = 1; br_valid = 1; br_result = 1; br_target = 32'h3400;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stall.addr", imem_addr, 32'h3108);
         check_ifid("stall", mem(32'h3104), 32'h3108, 1'b1);
         check_eq("stall.total", br_total_cnt, 32'd2);
         check_eq("stall.taken", br_taken_cnt, 32'd1);
      end
      stall = 0;
      step();
      clear_ctrl();
      check_eq("unstall.addr", imem_addr, 32'h3400);
      check_ifid("unstall", NOP, 32'h310C, 1'b0);
      check_eq("unstall.total", br_total_cnt, 32'd3);
      check_eq("unstall.taken", br_taken_cnt, 32'd2);

      // 5: misaligned jump, then branch-wins-over-jump
      jump = 1; jump_target = 32'h3202;
      step();
      clear_ctrl();
      check_eq("jmp.addr", imem_addr, 32'h3200);
      check_eq("jmp.misalign", {31'd0, pc_misalign}, 32'd1);
      check_eq("jmp.valid", {31'd0, ifid_valid}, 32'd0);
      br_valid = 1; br_result = 1; br_target = 32'h3500;
      jump = 1; jump_target = 32'h3600;
      step();
      clear_ctrl();
      check_eq("prio.addr", imem_addr, 32'h3500);
      check_eq("prio.misalign", {31'd0, pc_misalign}, 32'd1);
      check_eq("prio.total", br_total_cnt, 32'd4);
      check_eq("prio.taken", br_taken_cnt, 32'd3);
      step();
      check_eq("run.addr", imem_addr, 32'h3504);
      check_ifid("run", mem(32'h3500), 32'h3504, 1'b1);
      check_eq("run.misalign", {31'd0, pc_misalign}, 32'd1);

      // 6: PC wrap and asynchronous reset mid-cycle
      jump = 1; jump_target = 32'hFFFF_FFFC;
      step();
      clear_ctrl();
      check_eq("top.addr", imem_addr, 32'hFFFF_FFFC);
      step();
      check_eq("wrap.addr", imem_addr, 32'h0000_0000);
      check_ifid("wrap", mem(32'hFFFF_FFFC), 32'h0, 1'b1);
      #2;
      rst = 1;
      #1;
      check_eq("arst.addr", imem_addr, 32'h3000);
      check_ifid("arst", NOP, 32'h0, 1'b0);
      check_eq("arst.misalign", {31'd0, pc_misalign}, 32'd0);
      check_eq("arst.total", br_total_cnt, 32'd0);
      check_eq("arst.taken", br_taken_cnt, 32'd0);
      rst = 0;
      step();
      check_eq("boot.addr", imem_addr, 32'h3004);
      check_ifid("boot", mem(32'h3000), 32'h3004, 1'b1);

      // reset asserted while a redirect is pending discards the target
      jump = 1; jump_target = 32'h3700;
      #1;
      rst = 1;
      step();
      rst = 0;
      clear_ctrl();
      check_eq("rstjmp.addr", imem_addr, 32'h3000);
      step();
      check_eq("rstjmp.next", imem_addr, 32'h3004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
